// File: rtl/axi4_lite_write_slave.sv
// axi4_lite_write_slave: AXI4-Lite write responder feeding a valid/ready backend write port.
//
// Collects one AW beat and one W beat, in either order or together, then
// issues a single backend write and returns a B response.
//
// Ports:
//   CLK, RST_N                      clock (rising edge), asynchronous active-low reset
//   AW_ADDR/AW_PROT/AW_VALID/AW_READY  write address channel (AW_PROT ignored)
//   W_DATA/W_STRB/W_VALID/W_READY      write data channel
//   B_RESP/B_VALID/B_READY             write response channel (00 OKAY, 10 SLVERR, 11 DECERR)
//   MEM_WEN/MEM_ADDR/MEM_WDATA/MEM_WMASK  backend write request, held until MEM_WREADY
//   MEM_WREADY, MEM_WERR               backend accept and error (error sampled on accept)
//
// Build option: define AXI_WSLV_DECERR_EN to answer DECERR, without a backend
// write, for addresses outside [BASE_ADDR, BASE_ADDR+SIZE).
module axi4_lite_write_slave #(
    parameter int                ADDR_W    = 64,
    parameter int                DATA_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 64'h8000_0000,
    parameter logic [ADDR_W-1:0] SIZE      = 64'h0800_0000
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [ADDR_W-1:0]   AW_ADDR,
    input  logic [2:0]          AW_PROT,
    input  logic                AW_VALID,
    output logic                AW_READY,
    input  logic [DATA_W-1:0]   W_DATA,
    input  logic [DATA_W/8-1:0] W_STRB,
    input  logic                W_VALID,
    output logic                W_READY,
    output logic [1:0]          B_RESP,
    output logic                B_VALID,
    input  logic                B_READY,
    output logic                MEM_WEN,
    output logic [ADDR_W-1:0]   MEM_ADDR,
    output logic [DATA_W-1:0]   MEM_WDATA,
    output logic [DATA_W/8-1:0] MEM_WMASK,
    input  logic                MEM_WREADY,
    input  logic                MEM_WERR
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;
    logic [1:0]          state;
    logic                aw_hold;
    logic                w_hold;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W/8-1:0] strb_q;
    logic [1:0]          resp;
    logic                aw_hs;
    logic                w_hs;
    logic [ADDR_W-1:0]   addr_next;
    logic                addr_ok;
    logic                unused_cfg;
    assign AW_READY  = (state == IDLE) & ~aw_hold;
    assign W_READY   = (state == IDLE) & ~w_hold;
    assign aw_hs     = AW_VALID & AW_READY;
    assign w_hs      = W_VALID & W_READY;
    // Address as it will be held once this edge completes; decoded at WRITE entry.
    assign addr_next = aw_hs ? AW_ADDR : addr_q;
`ifdef AXI_WSLV_DECERR_EN
    // One extra bit keeps BASE_ADDR+SIZE from wrapping at the top of the address space.
    logic [ADDR_W:0] lo_bound;
    logic [ADDR_W:0] hi_bound;
    assign lo_bound = {1'b0, BASE_ADDR};
    assign hi_bound = lo_bound + {1'b0, SIZE};
    assign addr_ok  = ({1'b0, addr_next} >= lo_bound) && ({1'b0, addr_next} < hi_bound);
`else
    assign addr_ok  = 1'b1;
`endif
    assign unused_cfg = ^{AW_PROT, BASE_ADDR, SIZE};
    assign MEM_WEN   = state == WRITE;
    assign MEM_ADDR  = addr_q;
    assign MEM_WDATA = data_q;
    assign MEM_WMASK = strb_q;
    assign B_VALID   = state == RESP;
    assign B_RESP    = B_VALID ? resp : 2'b00;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            aw_hold <= 1'b0;
            w_hold  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            resp    <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (aw_hs) begin
                        aw_hold <= 1'b1;
                        addr_q  <= AW_ADDR;
                    end
                    if (w_hs) begin
                        w_hold <= 1'b1;
                        data_q <= W_DATA;
                        strb_q <= W_STRB;
                    end
                    if ((aw_hold | aw_hs) & (w_hold | w_hs)) begin
                        state <= addr_ok ? WRITE : RESP;
                        resp  <= addr_ok ? 2'b00 : 2'b11;
                    end
                end
                WRITE: begin
                    if (MEM_WREADY) begin
                        resp  <= MEM_WERR ? 2'b10 : 2'b00;
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (B_READY) begin
                        aw_hold <= 1'b0;
                        w_hold  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/axi4_lite_write_slave.md
# axi4_lite_write_slave

AXI4-Lite write-channel responder (slave) for the NPC bus fabric. Accepts AW and W beats in either order or together, performs one write to a simple synchronous backend (memory or device register file) via a valid/ready strobe, then returns a B response. Sits between the interconnect and a memory/peripheral model, serving as the far end of the core's AXI4-Lite write master.

## Interface
Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width; strobe width is DATA_W/8
- BASE_ADDR, 64'h8000_0000, first decoded address (used only with AXI_WSLV_DECERR_EN)
- SIZE, 64'h0800_0000, decoded region size in bytes (used only with AXI_WSLV_DECERR_EN)

Ports:
- CLK  in  1  clock, all logic on rising edge
- RST_N  in  1  asynchronous active-low reset
- AW_ADDR  in  ADDR_W  write address
- AW_PROT  in  3  accepted and ignored
- AW_VALID  in  1  address valid
- AW_READY  out  1  address ready
- W_DATA  in  DATA_W  write data
- W_STRB  in  DATA_W/8  byte strobes
- W_VALID  in  1  data valid
- W_READY  out  1  data ready
- B_RESP  out  2  response: 2'b00 OKAY, 2'b10 SLVERR, 2'b11 DECERR
- B_VALID  out  1  response valid
- B_READY  in  1  response ready
- MEM_WEN  out  1  backend write request
- MEM_ADDR  out  ADDR_W  latched address
- MEM_WDATA  out  DATA_W  latched data
- MEM_WMASK  out  DATA_W/8  latched strobes
- MEM_WREADY  in  1  backend accepts write this cycle
- MEM_WERR  in  1  backend error, sampled with MEM_WREADY

## Operation
- Registers: aw_hold (flag + ADDR), w_hold (flag + DATA + STRB), state, resp.
- States: IDLE, WRITE, RESP.
- IDLE: AW_READY = ~aw_hold; W_READY = ~w_hold. AW handshake (AW_VALID & AW_READY) latches AW_ADDR and sets aw_hold; W handshake likewise for W_DATA/W_STRB. Both may occur in the same cycle. When aw_hold & w_hold are both set at a clock edge -> WRITE.
- WRITE: AW_READY = W_READY = 0. MEM_WEN = 1 with MEM_ADDR/MEM_WDATA/MEM_WMASK from held registers, held stable until MEM_WREADY. On MEM_WEN & MEM_WREADY: resp <= MEM_WERR ? 2'b10 : 2'b00; -> RESP.
- RESP: B_VALID = 1, B_RESP = resp, stable until B_READY. On B_VALID & B_READY: clear aw_hold, w_hold -> IDLE.
- W_STRB == 0: write still issued with MEM_WMASK = 0; response OKAY.
- AW_PROT has no effect.

## Timing
- Reset (RST_N low, any cycle, including mid-transaction): state = IDLE, aw_hold = w_hold = 0, resp = 2'b00; B_VALID = 0, B_RESP = 2'b00, MEM_WEN = 0, MEM_ADDR/MEM_WDATA/MEM_WMASK = 0; AW_READY = W_READY = 1 after reset release. An in-flight transaction is discarded, with no response.
- Latency, same-cycle AW+W at edge 0 with MEM_WREADY = 1 tied: MEM_WEN high in cycle 1; B_VALID high in cycle 2; with B_READY = 1, readies high again in cycle 3. Peak throughput: one write per 3 cycles.
- AW before W: AW_READY drops the cycle after the AW handshake; W is accepted whenever it arrives; WRITE is entered the cycle after the second handshake. W before AW: symmetric.
- Second AW while aw_hold is set is not accepted (AW_READY = 0) until the current B completes. Same applies to W.
- READY outputs are combinational from state/hold flags only, never from VALID inputs. B_VALID/B_RESP and MEM_* are registered or decoded from state only.
- MEM_WREADY low for N cycles extends WRITE by N cycles, with MEM_* held constant.

## Configuration
- AXI_WSLV_DECERR_EN defined: at the WRITE-entry edge, if the held address is outside [BASE_ADDR, BASE_ADDR+SIZE), the state goes directly to RESP with resp = 2'b11 and MEM_WEN is never asserted. Comparisons are done in ADDR_W+1 bits so BASE_ADDR+SIZE does not wrap.
- Not defined: all addresses are forwarded to the backend; DECERR is never produced.

## Test plan
- Reset then same-cycle AW (0x8000_0010) + W (0x1122334455667788, strb 0xFF), MEM_WREADY = 1, B_READY = 1 -> MEM_WEN 1 cycle in cycle 1 with matching addr/data/mask; B_VALID cycle 2, B_RESP = 00; AW_READY = 1 in cycle 3.
- W 3 cycles before AW, strb 0x0F -> W_READY low after the W handshake; single MEM_WEN with mask 0x0F after AW; one B response only.
- MEM_WREADY held low 4 cycles, MEM_WERR = 1 on acceptance -> MEM_WEN high 5 cycles with stable outputs; B_RESP = 10.
- B_READY low 5 cycles -> B_VALID/B_RESP stable; new AW_VALID not accepted until B handshake, then accepted the next cycle.
- RST_N pulsed low during WRITE -> MEM_WEN drops immediately (async); no B_VALID afterwards; next write completes normally.
- With AXI_WSLV_DECERR_EN, AW 0x0000_1000 -> no MEM_WEN; B_RESP = 11. Without the macro -> MEM_WEN issued; B_RESP = 00.
